// File: rtl/nonrestoring_divider_if.sv
// Start/result handshake bundle for the sequential signed divider.
// The master side issues operands; the slave side (divider) returns results.
interface nonrestoring_divider_if #(
   parameter int WIDTH = 5
);
   logic                    start;
   logic signed [WIDTH-1:0] dividend;
   logic signed [WIDTH-1:0] divisor;
   logic                    busy;
   logic                    done;
   logic signed [WIDTH-1:0] quotient;
   logic signed [WIDTH-1:0] remainder;
   logic                    div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/nonrestoring_divider.sv
// Sequential signed divider: non-restoring iteration on operand magnitudes,
// one quotient bit per clock, followed by a single sign fix-up cycle.
module nonrestoring_divider #(
   parameter int WIDTH = 5
) (
   input logic                   clk,
   input logic                   n_rst,
   nonrestoring_divider_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CAL  = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic [CNT_W-1:0] cnt;

   logic signed [WIDTH:0] rem_r;
   logic [WIDTH-1:0]      qr;
   logic [WIDTH-1:0]      dm;
   logic                  sn, sd, dz;

   logic signed [WIDTH:0] dm_ext;
   logic signed [WIDTH:0] shifted;
   logic signed [WIDTH:0] rem_step;
   logic signed [WIDTH:0] rem_fix;
   logic [WIDTH-1:0]      q_out;
   logic [WIDTH-1:0]      r_out;
   logic                  accept;

   function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
      return ~v + ONE;
   endfunction

   // |-2^(W-1)| = 2^(W-1) is still representable as a W-bit unsigned value.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? neg(v) : v;
   endfunction

   assign accept   = (state == IDLE) && bus.start;
   assign bus.busy = (state == CAL) || (state == FIX);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = CAL;
         CAL:     if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Partial remainder stays within [-Dm, Dm), so W+1 signed bits never overflow.
   always_comb begin
      dm_ext   = $signed({1'b0, dm});
      shifted  = $signed({rem_r[WIDTH-1:0], qr[WIDTH-1]});
      rem_step = rem_r[WIDTH] ? (shifted + dm_ext) : (shifted - dm_ext);
      rem_fix  = rem_r[WIDTH] ? (rem_r + dm_ext) : rem_r;
      q_out    = dz ? '1 : ((sn ^ sd) ? neg(qr) : qr);
      r_out    = sn ? neg(rem_fix[WIDTH-1:0]) : rem_fix[WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state           <= IDLE;
         cnt             <= '0;
         bus.done        <= 1'b0;
         bus.quotient    <= '0;
         bus.remainder   <= '0;
         bus.div_by_zero <= 1'b0;
      end else begin
         state    <= state_nxt;
         bus.done <= (state == FIX);
         if (accept)
            cnt <= '0;
         else if (state == CAL)
            cnt <= cnt + CNT_W'(1);
         if (state == FIX) begin
            bus.quotient    <= $signed(q_out);
            bus.remainder   <= $signed(r_out);
            bus.div_by_zero <= dz;
         end
      end
   end

   // Working registers are fully reloaded on every accept, so they carry no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         sn    <= bus.dividend[WIDTH-1];
         sd    <= bus.divisor[WIDTH-1];
         qr    <= mag(bus.dividend);
         dm    <= mag(bus.divisor);
         rem_r <= '0;
         dz    <= (bus.divisor == '0);
      end else if (state == CAL) begin
         rem_r <= rem_step;
         qr    <= {qr[WIDTH-2:0], ~rem_step[WIDTH]};
      end
   end
endmodule

// File: tb/tb_nonrestoring_divider.sv
// Directed and random bench for nonrestoring_divider with a result scoreboard.
module tb_nonrestoring_divider;
   localparam int W = 5;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } exp_t;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   always #5 clk = ~clk;

   nonrestoring_divider_if #(.WIDTH(W)) dif ();
   nonrestoring_divider #(.WIDTH(W)) dut (.clk(clk), .n_rst(n_rst), .bus(dif));

   exp_t  expq[$];
   string tagq[$];
   int    total = 0;
   int    bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic signed [W-1:0] n, input logic signed [W-1:0] d);
      exp_t e;
      int ni, di;
      ni = n;
      di = d;
      if (di == 0) begin
         e.q  = '1;
         e.r  = n;
         e.dz = 1'b1;
      end else begin
         e.q  = W'(ni / di);
         e.r  = W'(ni % di);
         e.dz = 1'b0;
      end
      expq.push_back(e);
      tagq.push_back($sformatf("%0d/%0d", ni, di));
   endtask

   // Called at a falling edge; holds start for one rising edge.
   task automatic drive_start(input logic signed [W-1:0] n, input logic signed [W-1:0] d);
      dif.dividend = n;
      dif.divisor  = d;
      dif.start    = 1'b1;
      @(negedge clk);
      dif.start    = 1'b0;
   endtask

   task automatic issue(input logic signed [W-1:0] n, input logic signed [W-1:0] d);
      push_exp(n, d);
      drive_start(n, d);
   endtask

   task automatic wait_done(output int lat, output int bc);
      exp_t  e;
      string t;
      lat = 0;
      bc  = dif.busy ? 1 : 0;
      while (dif.done !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
         if (dif.busy === 1'b1) bc++;
      end
      if (dif.done !== 1'b1)
         chk("done_timeout", 32'(dif.done), 32'd1);
      else if (expq.size() == 0)
         chk("spurious_done", 32'(expq.size()), 32'd1);
      else begin
         e = expq.pop_front();
         t = tagq.pop_front();
         chk({t, "_q"}, 32'($unsigned(dif.quotient)), 32'(e.q));
         chk({t, "_r"}, 32'($unsigned(dif.remainder)), 32'(e.r));
         chk({t, "_dz"}, 32'(dif.div_by_zero), 32'(e.dz));
      end
   endtask

   initial begin
      int lat, bc, extra;
      int tn[9];
      int td[9];
      logic [W-1:0] held_q;
      logic signed [W-1:0] rn, rd;
      tn = '{-13, 13, -13, -16, -16, 3, 15, 7, 6};
      td = '{3, -3, -3, -1, 1, 7, 1, 0, 2};

      dif.start    = 1'b0;
      dif.dividend = '0;
      dif.divisor  = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(dif.busy), 32'd0);
      chk("rst_done", 32'(dif.done), 32'd0);
      chk("rst_q", 32'($unsigned(dif.quotient)), 32'd0);
      chk("rst_r", 32'($unsigned(dif.remainder)), 32'd0);
      chk("rst_dz", 32'(dif.div_by_zero), 32'd0);
      n_rst = 1'b1;
      @(negedge clk);

      issue(5'sd13, 5'sd3);
      wait_done(lat, bc);
      chk("latency", 32'(lat), 32'd6);
      chk("busy_cycles", 32'(bc), 32'd6);
      held_q = dif.quotient;
      @(negedge clk);
      chk("done_pulse", 32'(dif.done), 32'd0);
      chk("q_held", 32'($unsigned(dif.quotient)), 32'(held_q));

      for (int i = 0; i < 9; i++) begin
         issue(W'(tn[i]), W'(td[i]));
         wait_done(lat, bc);
      end

      // start pulsed mid-computation with different operands must be ignored
      issue(5'sd13, 5'sd3);
      repeat (2) @(negedge clk);
      drive_start(5'sd7, 5'sd0);
      wait_done(lat, bc);
      extra = 0;
      repeat (8) begin
         @(negedge clk);
         if (dif.done === 1'b1) extra++;
      end
      chk("no_extra_done", 32'(extra), 32'd0);

      issue(-5'sd16, -5'sd1);
      wait_done(lat, bc);
      issue(5'sd5, 5'sd2);
      wait_done(lat, bc);
      chk("b2b_latency", 32'(lat), 32'd6);

      drive_start(5'sd15, 5'sd1);
      repeat (2) @(negedge clk);
      n_rst = 1'b0;
      #1;
      chk("abort_busy", 32'(dif.busy), 32'd0);
      chk("abort_done", 32'(dif.done), 32'd0);
      chk("abort_q", 32'($unsigned(dif.quotient)), 32'd0);
      chk("abort_r", 32'($unsigned(dif.remainder)), 32'd0);
      chk("abort_dz", 32'(dif.div_by_zero), 32'd0);
      @(negedge clk);
      n_rst = 1'b1;
      extra = 0;
      repeat (8) begin
         @(negedge clk);
         if (dif.done === 1'b1) extra++;
      end
      chk("abort_no_done", 32'(extra), 32'd0);
      issue(-5'sd7, 5'sd2);
      wait_done(lat, bc);
      chk("post_rst_latency", 32'(lat), 32'd6);

      for (int i = 0; i < 10000; i++) begin
         rn = W'($urandom_range(0, 31));
         rd = W'($urandom_range(1, 31));
         issue(rn, rd);
         wait_done(lat, bc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
